// File: rtl/ahb_sram_if.sv
// ahb_sram_if: AHB-Lite slave front end for a single-port synchronous SRAM
// (1-cycle read latency, per-byte write enables).
//
// Ports
//   hclk, hreset        clock, synchronous active-high reset
//   hsel, hready        slave select, bus-level ready
//   htrans, hwrite      transfer type, direction
//   hsize, haddr        transfer size, byte address
//   hwdata              write data (data phase)
//   hready_resp, hresp  slave ready, response (00 OKAY, 01 ERROR)
//   hrdata              read data (zero outside a completing read)
//   sram_cs, sram_we    SRAM chip select, byte write enables (0000 = read)
//   sram_addr           SRAM word address
//   sram_wdata          SRAM write data
//   sram_rdata          SRAM read data, valid the cycle after a read select
//
// Build option
//   AHB_SRAM_ERR_RESP_EN  defined: illegal transfers get a two-cycle ERROR
//                         response. Undefined: they complete OKAY at zero
//                         wait with no SRAM access and hrdata=0.

module ahb_sram_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic                  hready,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [31:0]           haddr,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic                  hready_resp,
    output logic [1:0]            hresp,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  sram_cs,
    output logic [3:0]            sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

`ifdef AHB_SRAM_ERR_RESP_EN
    typedef enum logic [2:0] {S_IDLE, S_DATA, S_RD_STALL, S_ERR1, S_ERR2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_RD_STALL} state_t;
`endif

    state_t                r_state;
    logic                  r_dp_wr;    // in S_DATA: 1 = write data phase, 0 = read
    logic [ADDR_WIDTH-1:0] r_addr;     // pending write address or stalled read address
    logic [3:0]            r_be;

    logic                  w_accept;
    logic                  w_illegal;
    logic                  w_access;
    logic                  w_wr_dp;
    logic                  w_rd_dp;
    logic                  w_rd_issue;
    logic                  w_stall;
    logic [3:0]            w_be;
    logic [ADDR_WIDTH-1:0] w_word_addr;

    // Own ready gates acceptance so a stalled address is never taken twice
    assign w_accept    = hsel & hready & htrans[1] & hready_resp;
    assign w_word_addr = haddr[ADDR_WIDTH+1:2];
    assign w_wr_dp     = (r_state == S_DATA) & r_dp_wr;
    assign w_rd_dp     = (r_state == S_DATA) & ~r_dp_wr;
    assign w_stall     = (r_state == S_RD_STALL);

    // Size/alignment/range legality
    always_comb begin
        w_illegal = 1'b0;
        if (hsize > 3'd2)                            w_illegal = 1'b1;
        if ((hsize == 3'd1) && haddr[0])             w_illegal = 1'b1;
        if ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) w_illegal = 1'b1;
        if ((haddr >> (ADDR_WIDTH + 2)) != 32'd0)    w_illegal = 1'b1;
    end

    // Little-endian byte lanes
    always_comb begin
        case (hsize)
            3'd0:    w_be = 4'(4'b0001 << haddr[1:0]);
            3'd1:    w_be = haddr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    assign w_access   = w_accept & ~w_illegal;
    // A read colliding with a write data phase is deferred to the stall cycle
    assign w_rd_issue = w_access & ~hwrite & ~w_wr_dp;

    // State and pending-phase registers
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state <= S_IDLE;
            r_dp_wr <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
        end else begin
            case (r_state)
                S_RD_STALL: begin
                    r_state <= S_DATA;
                    r_dp_wr <= 1'b0;
                end
`ifdef AHB_SRAM_ERR_RESP_EN
                S_ERR1: r_state <= S_ERR2;
`endif
                default: begin
                    if (w_access) begin
                        if (hwrite) begin
                            r_state <= S_DATA;
                            r_dp_wr <= 1'b1;
                            r_addr  <= w_word_addr;
                            r_be    <= w_be;
                        end else if (w_wr_dp) begin
                            r_state <= S_RD_STALL;
                            r_addr  <= w_word_addr;
                        end else begin
                            r_state <= S_DATA;
                            r_dp_wr <= 1'b0;
                        end
                    end else begin
`ifdef AHB_SRAM_ERR_RESP_EN
                        r_state <= (w_accept && w_illegal) ? S_ERR1 : S_IDLE;
`else
                        r_state <= S_IDLE;
`endif
                    end
                end
            endcase
        end
    end

    // SRAM request: write data phase, stalled read, or fresh read
    always_comb begin
        sram_cs    = w_wr_dp | w_stall | w_rd_issue;
        sram_we    = w_wr_dp ? r_be : 4'b0000;
        sram_wdata = w_wr_dp ? hwdata : '0;
        if (w_wr_dp || w_stall) sram_addr = r_addr;
        else if (w_rd_issue)    sram_addr = w_word_addr;
        else                    sram_addr = '0;
    end

    // Bus response
    assign hrdata = w_rd_dp ? sram_rdata : '0;
`ifdef AHB_SRAM_ERR_RESP_EN
    assign hready_resp = ~(w_stall | (r_state == S_ERR1));
    assign hresp       = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? 2'b01 : 2'b00;
`else
    assign hready_resp = ~w_stall;
    assign hresp       = 2'b00;
`endif

endmodule

// File: doc/ahb_sram_if.md
Name: ahb_sram_if

Overview:
- AHB-Lite slave front end for the on-chip SRAM.
- Sits directly downstream of the AHB bus interface. It consumes hsel/haddr/htrans/hsize/hwrite/hwdata/hready and returns hready_resp/hresp/hrdata.
- Converts pipelined AHB address/data phases into single-port synchronous SRAM accesses (1-cycle read latency) with per-byte write enables.
- Inserts one wait state on write-then-read port conflicts.

Parameters:
- ADDR_WIDTH, 16, SRAM word-address width. Byte range 0 .. 2^(ADDR_WIDTH+2)-1.
- DATA_WIDTH, 32, bus/SRAM data width. Only 32 is supported.

Ports:
- hclk  input  1  bus clock; all logic on rising edge.
- hreset  input  1  reset; synchronous, active-high.
- hsel  input  1  slave select.
- hready  input  1  bus-level ready; address phase accepted only when high.
- htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  input  1  1=write, 0=read.
- hsize  input  3  0=byte, 1=half, 2=word.
- haddr  input  32  byte address.
- hwdata  input  32  write data; valid in the data phase.
- hready_resp  output  1  slave ready.
- hresp  output  2  00=OKAY, 01=ERROR.
- hrdata  output  32  read data.
- sram_cs  output  1  SRAM chip select.
- sram_we  output  4  byte write enables; 0000 = read.
- sram_addr  output  ADDR_WIDTH  SRAM word address.
- sram_wdata  output  32  SRAM write data.
- sram_rdata  input  32  SRAM read data; valid one cycle after a read cs.

Behaviour:
- Accept condition: accept = hsel & hready & htrans[1]. IDLE, BUSY or !hsel → no access, OKAY, zero wait.
- Reset (hreset=1 at a clock edge): state=IDLE, pending phase dropped, hready_resp=1, hresp=00, hrdata=0, sram_cs=0, sram_we=0, sram_addr=0, sram_wdata=0. Reset mid-burst aborts the burst silently.
- Byte enables (little-endian):
  - size0: we = 1<<haddr[1:0].
  - size1: haddr[1] ? 1100 : 0011.
  - size2: 1111.
- Illegal transfer: hsize>2, size1 with haddr[0]=1, size2 with haddr[1:0]!=0, or haddr[31:ADDR_WIDTH+2]!=0.
- States:
  - IDLE/DATA: normal pipelining.
  - RD_STALL: one wait state for a conflicted read.
  - ERR1, ERR2: two-cycle error response.
- Read, address phase N: sram_cs=1, sram_we=0000, sram_addr=haddr[ADDR_WIDTH+1:2], issued combinationally in cycle N. Data phase N+1: hready_resp=1, hrdata=sram_rdata. Zero wait.
- Write: address/size/byte-enables registered at N. Data phase N+1: sram_cs=1, sram_we=registered enables, sram_addr=registered address, sram_wdata=hwdata. hready_resp=1.
- Conflict: read accepted in the same cycle as a write data phase.
  - Read address is latched; state → RD_STALL.
  - Next cycle: read issued from latch, hready_resp=0, hresp=00.
  - Following cycle: hready_resp=1, hrdata=sram_rdata.
  - A write to A followed by a read of A returns the new data.
- hrdata = 0 whenever not in a completing read data phase.
- Error: cycle 1 hready_resp=0, hresp=01; cycle 2 hready_resp=1, hresp=01; no SRAM access. An address accepted during ERR2 is handled normally.
- Back-to-back reads, writes and read→write run at zero wait.

Optional Feature:
- Macro: AHB_SRAM_ERR_RESP_EN.
- Defined: illegal transfers produce the two-cycle ERROR response.
- Undefined: illegal transfers return OKAY at zero wait. No SRAM access is made; reads return hrdata=0. ERR1/ERR2 logic is not compiled.

Test Plan:
- Reset then idle: hreset=1 for 2 cycles, htrans=00 → hready_resp=1, hresp=00, hrdata=0, sram_cs=0 throughout.
- Word write then read: write 0xDEADBEEF to 0x10 (NONSEQ), next transfer IDLE, then read 0x10 → sram_we=1111 at data phase, sram_addr=0x4; read data phase hrdata=0xDEADBEEF with zero wait.
- Byte/half lanes: size0 write 0xAA at 0x13 → sram_we=1000. Size1 write at 0x12 → sram_we=1100. Read word 0x10 → upper bytes updated, lower bytes unchanged.
- Write→read conflict: write 0x11223344 to 0x20, read 0x20 in the next address phase → one cycle hready_resp=0, then hrdata=0x11223344.
- Illegal transfer with macro: word read at 0x02 → cycle 1 hready_resp=0/hresp=01, cycle 2 hready_resp=1/hresp=01, sram_cs=0. Without the macro → OKAY, hrdata=0.
- Reset mid-burst: 4-beat SEQ write burst, hreset asserted in beat 2 → sram_cs=0 next cycle; beats 3-4 never written; read-back shows the original data.
